mod_counter: RTL and testbench

Parametrised modulo-N time counter, the successor of the fixed 0–59 seconds counter. One instance covers seconds (N=60), minutes (N=60) and hours (N=24 or 12); instances cascade synchronously on one clock through a terminal-count output. Adds enable, up/down counting, clear, time-set load with range checking, and registered two-digit BCD outputs that drive the display decoders directly.

---
 rtl/clk_pkg.sv | 19 +
 rtl/bin_to_bcd2.sv | 29 ++
 rtl/mod_counter.sv | 80 ++++++++
 tb/tb_mod_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_pkg.sv
// rtl/clk_pkg.sv - shared moduli and width helper for the clock counter chain
package clk_pkg;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HR24_MOD = 24;
  localparam int HR12_MOD = 12;

  // Bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/bin_to_bcd2.sv
// rtl/bin_to_bcd2.sv - combinational binary (<100) to two-digit BCD converter
module bin_to_bcd2
  import clk_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] i_bin,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_ones
);

  // Working width is at least 7 bits so the constant 10 always fits.
  localparam int BW = (WIDTH > 7) ? WIDTH : 7;

  logic [BW-1:0] w_rem;

  always_comb begin
    w_rem  = BW'(i_bin);
    o_tens = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (w_rem >= BW'(10)) begin
        w_rem  = w_rem - BW'(10);
        o_tens = o_tens + 4'd1;
      end
    end
    o_ones = w_rem[3:0];
  end

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-N up/down time counter with load, clear, BCD outputs
module mod_counter
  import clk_pkg::*;
#(
  parameter int MODULUS = SEC_MOD,
  parameter int WIDTH   = 6
) (
  input  logic             sig_1Hz,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             tc,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > 100 || WIDTH < clog2(MODULUS)) begin : g_param_check
    $error("mod_counter: MODULUS must be 2..100 and fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [3:0]       r_tens;
  logic [3:0]       r_ones;
  logic             r_load_err;

  logic [WIDTH-1:0] w_next_count;
  logic             w_next_err;
  logic [3:0]       w_next_tens;
  logic [3:0]       w_next_ones;

  always_comb begin
    w_next_count = r_count;
    w_next_err   = 1'b0;
    if (clear) begin
      w_next_count = '0;
    end else if (load) begin
      if (load_val <= MAX_CNT) w_next_count = load_val;
      else                     w_next_err   = 1'b1;
    end else if (en) begin
      if (up_dn) w_next_count = (r_count == MAX_CNT) ? '0 : r_count + ONE;
      else       w_next_count = (r_count == '0) ? MAX_CNT : r_count - ONE;
    end
  end

  // Digits come from the next count so they update on the same edge as count.
  bin_to_bcd2 #(.WIDTH(WIDTH)) u_bcd (
    .i_bin  (w_next_count),
    .o_tens (w_next_tens),
    .o_ones (w_next_ones)
  );

  always_ff @(posedge sig_1Hz or posedge reset) begin
    if (reset) begin
      r_count    <= '0;
      r_tens     <= 4'd0;
      r_ones     <= 4'd0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_next_count;
      r_tens     <= w_next_tens;
      r_ones     <= w_next_ones;
      r_load_err <= w_next_err;
    end
  end

  assign tc       = en & ((up_dn & (r_count == MAX_CNT)) | (~up_dn & (r_count == '0)));
  assign count    = r_count;
  assign tens     = r_tens;
  assign ones     = r_ones;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter
module tb_mod_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       clear;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] count;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       tc;
  logic       load_err;

  logic       hr_clear;
  logic       hr_load;
  logic [4:0] hr_load_val;
  logic [4:0] hr_count;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic       hr_tc;
  logic       hr_load_err;

  int total;
  int bad;

  mod_counter #(.MODULUS(60), .WIDTH(6)) u_sec (
    .sig_1Hz  (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tens     (tens),
    .ones     (ones),
    .tc       (tc),
    .load_err (load_err)
  );

  mod_counter #(.MODULUS(24), .WIDTH(5)) u_hr (
    .sig_1Hz  (clk),
    .reset    (reset),
    .en       (tc),
    .up_dn    (up_dn),
    .clear    (hr_clear),
    .load     (hr_load),
    .load_val (hr_load_val),
    .count    (hr_count),
    .tens     (hr_tens),
    .ones     (hr_ones),
    .tc       (hr_tc),
    .load_err (hr_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    en = 1'b0;
    up_dn = 1'b1;
    clear = 1'b0;
    load = 1'b0;
    load_val = '0;
    hr_clear = 1'b0;
    hr_load = 1'b0;
    hr_load_val = '0;

    #1;
    check("rst_count", 32'(count), 0);
    check("rst_tens", 32'(tens), 0);
    check("rst_ones", 32'(ones), 0);
    check("rst_err", 32'(load_err), 0);
    check("rst_tc_idle", 32'(tc), 0);
    up_dn = 1'b0;
    en = 1'b1;
    #1;
    check("rst_tc_down", 32'(tc), 1);
    en = 1'b0;
    up_dn = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Full up-count sweep including the wrap
    en = 1'b1;
    up_dn = 1'b1;
    check("up_tc_at0", 32'(tc), 0);
    for (int i = 1; i <= 60; i++) begin
      step();
      check($sformatf("up_count_%0d", i), 32'(count), 32'(i % 60));
      check($sformatf("up_tens_%0d", i), 32'(tens), 32'((i % 60) / 10));
      check($sformatf("up_ones_%0d", i), 32'(ones), 32'((i % 60) % 10));
      check($sformatf("up_tc_%0d", i), 32'(tc), (i == 59) ? 32'd1 : 32'd0);
    end

    // Down from 0 wraps to 59
    up_dn = 1'b0;
    #1;
    check("dn_tc_at0", 32'(tc), 1);
    step();
    check("dn_count_59", 32'(count), 59);
    check("dn_tens_59", 32'(tens), 5);
    check("dn_ones_59", 32'(ones), 9);
    check("dn_tc_59", 32'(tc), 0);
    step();
    check("dn_count_58", 32'(count), 58);
    check("dn_tens_58", 32'(tens), 5);
    check("dn_ones_58", 32'(ones), 8);

    // Load beats enable; out-of-range load rejected
    up_dn = 1'b1;
    load = 1'b1;
    load_val = 6'd37;
    step();
    check("ld37_count", 32'(count), 37);
    check("ld37_tens", 32'(tens), 3);
    check("ld37_ones", 32'(ones), 7);
    check("ld37_err", 32'(load_err), 0);
    load_val = 6'd60;
    step();
    check("ld60_count", 32'(count), 37);
    check("ld60_err", 32'(load_err), 1);
    load_val = 6'd59;
    step();
    check("ld59_count", 32'(count), 59);
    check("ld59_err", 32'(load_err), 0);
    load_val = 6'd63;
    step();
    check("ld63_err", 32'(load_err), 1);
    load = 1'b0;
    en = 1'b0;
    step();
    check("ld63_err_drop", 32'(load_err), 0);
    check("ld63_count", 32'(count), 59);

    // Clear beats load and enable
    load = 1'b1;
    load_val = 6'd20;
    step();
    check("ld20_count", 32'(count), 20);
    clear = 1'b1;
    en = 1'b1;
    load_val = 6'd62;
    step();
    check("clr_count", 32'(count), 0);
    check("clr_err", 32'(load_err), 0);
    check("clr_ones", 32'(ones), 0);
    clear = 1'b0;
    load = 1'b0;
    en = 1'b0;
    step();
    check("idle_count", 32'(count), 0);

    // Cascade: 23/59 -> 00/00 on one edge
    load = 1'b1;
    load_val = 6'd59;
    hr_load = 1'b1;
    hr_load_val = 5'd23;
    step();
    check("cas_sec_ld", 32'(count), 59);
    check("cas_hr_ld", 32'(hr_count), 23);
    load = 1'b0;
    hr_load = 1'b0;
    en = 1'b1;
    up_dn = 1'b1;
    #1;
    check("cas_sec_tc", 32'(tc), 1);
    check("cas_hr_tc", 32'(hr_tc), 1);
    step();
    check("cas_sec_wrap", 32'(count), 0);
    check("cas_hr_wrap", 32'(hr_count), 0);
    check("cas_hr_tens", 32'(hr_tens), 0);
    check("cas_hr_ones", 32'(hr_ones), 0);
    check("cas_hr_err", 32'(hr_load_err), 0);
    step();
    check("cas_sec_1", 32'(count), 1);
    check("cas_hr_hold", 32'(hr_count), 0);

    // Asynchronous reset mid-cycle
    en = 1'b0;
    load = 1'b1;
    load_val = 6'd45;
    step();
    check("ar_ld45", 32'(count), 45);
    load = 1'b0;
    en = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_tens", 32'(tens), 0);
    check("ar_ones", 32'(ones), 0);
    #2;
    reset = 1'b0;
    step();
    check("ar_resume_count", 32'(count), 1);
    check("ar_resume_ones", 32'(ones), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
